// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raw beam counters, syncs, visible/vblank flags,
// pixel-replicated coordinates and line/frame strobes, advanced by a pixel-clock enable.
//
// Ports:
//   clk, rst (sync, active-high), en (pixel enable)
//   hsync, vsync, visible, vblank             - decoded beam state
//   hcount, vcount                            - raw beam position
//   px_x, px_y                                - scaled beam position
//   line_start, frame_start                   - one-clk strobes on hcount / frame wrap
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int H_SCALE   = 1,
    parameter int V_SCALE   = 1,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          visible,
    output logic          vblank,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic [CW-1:0] px_x,
    output logic [CW-1:0] px_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_END = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_END = CW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] HS_TOP = CW'(H_SCALE - 1);
    localparam logic [CW-1:0] VS_TOP = CW'(V_SCALE - 1);

    localparam logic HP = (HSYNC_POL != 0);
    localparam logic VP = (VSYNC_POL != 0);

    // Replication sub-counters: position inside the current scaled cell
    logic [CW-1:0] h_sub;
    logic [CW-1:0] v_sub;

    logic          h_wrap;
    logic [CW-1:0] h_nx;
    logic [CW-1:0] v_nx;
    logic [CW-1:0] px_x_nx;
    logic [CW-1:0] px_y_nx;
    logic [CW-1:0] h_sub_nx;
    logic [CW-1:0] v_sub_nx;

    // Next beam state; all registered outputs are decoded from it so that
    // they line up with the counters in the same cycle.
    always_comb begin
        h_wrap   = (hcount == H_LAST);
        h_nx     = h_wrap ? '0 : hcount + ONE;
        v_nx     = vcount;
        px_x_nx  = px_x;
        h_sub_nx = h_sub;
        px_y_nx  = px_y;
        v_sub_nx = v_sub;

        if (h_wrap) begin
            v_nx = (vcount == V_LAST) ? '0 : vcount + ONE;
        end

        if (h_nx == '0) begin
            px_x_nx  = '0;
            h_sub_nx = '0;
        end else if (h_nx < H_VIS) begin
            if (h_sub == HS_TOP) begin
                h_sub_nx = '0;
                px_x_nx  = px_x + ONE;
            end else begin
                h_sub_nx = h_sub + ONE;
            end
        end

        // Vertical replication only moves on a line wrap
        if (h_wrap) begin
            if (v_nx == '0) begin
                px_y_nx  = '0;
                v_sub_nx = '0;
            end else if (v_nx < V_VIS) begin
                if (v_sub == VS_TOP) begin
                    v_sub_nx = '0;
                    px_y_nx  = px_y + ONE;
                end else begin
                    v_sub_nx = v_sub + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Park on the last pixel so the first enabled step starts a clean frame
            hcount      <= H_LAST;
            vcount      <= V_LAST;
            px_x        <= '0;
            px_y        <= '0;
            h_sub       <= '0;
            v_sub       <= '0;
            visible     <= 1'b0;
            vblank      <= 1'b1;
            hsync       <= ~HP;
            vsync       <= ~VP;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hcount      <= h_nx;
            vcount      <= v_nx;
            px_x        <= px_x_nx;
            px_y        <= px_y_nx;
            h_sub       <= h_sub_nx;
            v_sub       <= v_sub_nx;
            visible     <= (h_nx < H_VIS) && (v_nx < V_VIS);
            vblank      <= (v_nx >= V_VIS);
            hsync       <= ((h_nx >= HS_BEG) && (h_nx < HS_END)) ? HP : ~HP;
            vsync       <= ((v_nx >= VS_BEG) && (v_nx < VS_END)) ? VP : ~VP;
            line_start  <= (h_nx == '0);
            frame_start <= (h_nx == '0) && (v_nx == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a 14x8 mode, with a scale-1 and a scale-2 instance
// sharing clock, reset and enable.
module tb_vga_timing_gen;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    logic          a_hsync, a_vsync, a_visible, a_vblank, a_ls, a_fs;
    logic [CW-1:0] a_hcount, a_vcount, a_px_x, a_px_y;
    logic          b_hsync, b_vsync, b_visible, b_vblank, b_ls, b_fs;
    logic [CW-1:0] b_hcount, b_vcount, b_px_x, b_px_y;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .H_SCALE(1), .V_SCALE(1), .CW(CW)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .hsync(a_hsync), .vsync(a_vsync), .visible(a_visible), .vblank(a_vblank),
        .hcount(a_hcount), .vcount(a_vcount), .px_x(a_px_x), .px_y(a_px_y),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .H_SCALE(2), .V_SCALE(2), .CW(CW)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .hsync(b_hsync), .vsync(b_vsync), .visible(b_visible), .vblank(b_vblank),
        .hcount(b_hcount), .vcount(b_vcount), .px_x(b_px_x), .px_y(b_px_y),
        .line_start(b_ls), .frame_start(b_fs)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference beam position, advanced only on enabled steps
    int ref_h, ref_v;
    bit ref_ls, ref_fs, fresh;

    int cnt_hs, cnt_vs, cnt_vb, cnt_vis, cnt_ls, cnt_fs;
    int cyc, last_fs;
    bit found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        chk("hcount", a_hcount, ref_h);
        chk("vcount", a_vcount, ref_v);
        chk("visible", a_visible, (ref_h < 8 && ref_v < 4) ? 1 : 0);
        chk("vblank", a_vblank, (ref_v >= 4) ? 1 : 0);
        chk("hsync", a_hsync, (ref_h >= 10 && ref_h <= 12) ? 0 : 1);
        chk("vsync", a_vsync, (ref_v >= 5 && ref_v <= 6) ? 0 : 1);
        chk("line_start", a_ls, ref_ls);
        chk("frame_start", a_fs, ref_fs);
        chk("px_x_s1", a_px_x, fresh ? 0 : (ref_h < 8 ? ref_h : 7));
        chk("px_y_s1", a_px_y, fresh ? 0 : (ref_v < 4 ? ref_v : 3));
        chk("hcount_s2", b_hcount, ref_h);
        chk("px_x_s2", b_px_x, fresh ? 0 : (ref_h < 8 ? ref_h / 2 : 3));
        chk("px_y_s2", b_px_y, fresh ? 0 : (ref_v < 4 ? ref_v / 2 : 1));
        chk("fs_s2", b_fs, ref_fs);
    endtask

    task automatic step(input bit e);
        rst = 1'b0;
        en  = e;
        tick();
        if (e) begin
            if (ref_h == 13) begin
                ref_h = 0;
                ref_v = (ref_v == 7) ? 0 : ref_v + 1;
            end else begin
                ref_h = ref_h + 1;
            end
            fresh = 1'b0;
        end
        ref_ls = e && (ref_h == 0);
        ref_fs = ref_ls && (ref_v == 0);
        check_all();
    endtask

    task automatic do_reset(input bit e);
        rst = 1'b1;
        en  = e;
        tick();
        ref_h  = 13;
        ref_v  = 7;
        ref_ls = 1'b0;
        ref_fs = 1'b0;
        fresh  = 1'b1;
        check_all();
        chk("rst_hcount", a_hcount, 13);
        chk("rst_vcount", a_vcount, 7);
        chk("rst_hsync", a_hsync, 1);
        chk("rst_vsync", a_vsync, 1);
        chk("rst_vblank", a_vblank, 1);
        chk("rst_visible", a_visible, 0);
    endtask

    task automatic tally();
        if (a_hsync == 1'b0) cnt_hs++;
        if (a_vsync == 1'b0) cnt_vs++;
        if (a_vblank) cnt_vb++;
        if (a_visible) cnt_vis++;
        if (a_ls) cnt_ls++;
        if (a_fs) cnt_fs++;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        tick();

        // Reset, then the first enabled step lands on (0,0)
        do_reset(1'b0);
        step(1'b1);
        chk("first_fs", a_fs, 1);
        chk("first_ls", a_ls, 1);
        chk("first_vis", a_visible, 1);

        // One full frame with continuous enable
        cnt_hs = 0; cnt_vs = 0; cnt_vb = 0;
        cnt_vis = 0; cnt_ls = 0; cnt_fs = 0;
        tally();
        for (int i = 0; i < 111; i++) begin
            step(1'b1);
            tally();
        end
        chk("hsync_low_clks", cnt_hs, 24);
        chk("vsync_low_clks", cnt_vs, 28);
        chk("vblank_clks", cnt_vb, 56);
        chk("visible_clks", cnt_vis, 32);
        chk("line_starts", cnt_ls, 8);
        chk("frame_starts", cnt_fs, 1);

        // frame_start spacing
        cyc     = 111;
        last_fs = 0;
        for (int i = 0; i < 113; i++) begin
            step(1'b1);
            cyc++;
            if (a_fs) begin
                chk("fs_period", cyc - last_fs, 112);
                last_fs = cyc;
            end
        end
        chk("fs_seen", last_fs, 224);

        // Enable pattern 1,0,0,1 against the reference model
        for (int i = 0; i < 64; i++) begin
            step((i % 4 == 0) || (i % 4 == 3));
        end

        // Reset mid-line at (5,2) with en held high
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (ref_h == 5 && ref_v == 2) found = 1'b1;
            else step(1'b1);
        end
        chk("seek_5_2", found, 1);
        do_reset(1'b1);
        step(1'b1);
        chk("resume_fs", a_fs, 1);
        chk("resume_h", a_hcount, 0);
        chk("resume_v", a_vcount, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
